// File: rtl/pwm_pkg.sv
// Shared PWM definitions: default PWM period and the capture FSM state encoding.
package pwm_pkg;

  localparam int unsigned PWM_INTERVAL_DEFAULT = 1200;

  typedef enum logic [1:0] {
    S_WAIT,
    S_HIGH,
    S_LOW,
    S_STUCK
  } cap_state_e;

endpackage

// File: rtl/pwm_sync.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module pwm_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rising-to-rising period of an asynchronous PWM input,
// publishing each completed period and flagging an input with no rising edges.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = PWM_INTERVAL_DEFAULT,
  parameter int unsigned TIMEOUT      = 2 * PWM_INTERVAL,
  localparam int unsigned DW          = $clog2(PWM_INTERVAL + 1),
  localparam int unsigned CW          = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pwm_in,
  output logic [DW-1:0] pwm_value,
  output logic [CW-1:0] period,
  output logic          valid,
  output logic          stuck
);

  localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT);
  localparam logic [CW-1:0] INTERVAL_C = CW'(PWM_INTERVAL);
  localparam logic [DW-1:0] VALUE_MAX  = DW'(PWM_INTERVAL);
  localparam logic [CW-1:0] ONE        = CW'(1);

  cap_state_e    state;
  logic          pwm_s;
  logic          pwm_d;
  logic          rise;
  logic          fall;
  logic [CW-1:0] hi_cnt;
  logic [CW-1:0] per_cnt;
  logic [CW-1:0] idle_cnt;
  logic [DW-1:0] hi_clamped;

  pwm_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pwm_in),
    .q   (pwm_s)
  );

  assign rise       = pwm_s & ~pwm_d;
  assign fall       = ~pwm_s & pwm_d;
  assign hi_clamped = (hi_cnt > INTERVAL_C) ? VALUE_MAX : hi_cnt[DW-1:0];

  // Counters only advance while below TIMEOUT, so they saturate there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_WAIT;
      pwm_d     <= 1'b0;
      hi_cnt    <= '0;
      per_cnt   <= '0;
      idle_cnt  <= '0;
      pwm_value <= '0;
      period    <= '0;
      valid     <= 1'b0;
      stuck     <= 1'b0;
    end else begin
      pwm_d <= pwm_s;
      valid <= 1'b0;
      unique case (state)
        S_WAIT: begin
          if (rise) begin
            state   <= S_HIGH;
            hi_cnt  <= ONE;
            per_cnt <= ONE;
          end else if (idle_cnt >= TIMEOUT_C) begin
            state     <= S_STUCK;
            pwm_value <= pwm_s ? VALUE_MAX : '0;
            period    <= '0;
            stuck     <= 1'b1;
            valid     <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + ONE;
          end
        end
        S_HIGH: begin
          if (per_cnt >= TIMEOUT_C) begin
            state     <= S_STUCK;
            pwm_value <= pwm_s ? VALUE_MAX : '0;
            period    <= '0;
            stuck     <= 1'b1;
            valid     <= 1'b1;
          end else if (fall) begin
            state   <= S_LOW;
            per_cnt <= per_cnt + ONE;
          end else begin
            hi_cnt  <= hi_cnt + ONE;
            per_cnt <= per_cnt + ONE;
          end
        end
        S_LOW: begin
          // A rise in the same cycle as the timeout still closes a normal period.
          if (rise) begin
            state     <= S_HIGH;
            pwm_value <= hi_clamped;
            period    <= per_cnt;
            stuck     <= 1'b0;
            valid     <= 1'b1;
            hi_cnt    <= ONE;
            per_cnt   <= ONE;
          end else if (per_cnt >= TIMEOUT_C) begin
            state     <= S_STUCK;
            pwm_value <= pwm_s ? VALUE_MAX : '0;
            period    <= '0;
            stuck     <= 1'b1;
            valid     <= 1'b1;
          end else begin
            per_cnt <= per_cnt + ONE;
          end
        end
        S_STUCK: begin
          // stuck stays set until the first full period after recovery publishes.
          if (rise) begin
            state   <= S_HIGH;
            hi_cnt  <= ONE;
            per_cnt <= ONE;
          end
        end
      endcase
    end
  end

endmodule
